// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - 8051 instruction sequencer with operand fetch, multi-cycle execute and interrupt entry
//
// Purpose: steps START -> FETCH -> DECODE -> [OPERAND] -> EXECUTE -> (INT) -> FETCH,
// pacing program-memory reads with mem_ready and entering interrupts only at
// instruction boundaries.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   mem_data     program memory read byte
//   mem_ready    mem_data valid this cycle
//   instr_bytes  decoder instruction length (sampled in DECODE)
//   exec_cycles  decoder execute-cycle count (sampled in DECODE)
//   int_req      level-sensitive interrupt requests, index 0 highest priority
//   int_en       global interrupt enable
//   reti         return-from-interrupt pulse, clears in_service
//   fetch        high in FETCH and OPERAND
//   decode       high in DECODE
//   execute      high in EXECUTE
//   exec_last    high on the final EXECUTE cycle
//   pc_inc       fetch & mem_ready
//   opcode_q     latched opcode
//   operand_q    latched operand bytes, byte 1 in the low bits
//   int_ack      one-hot acknowledge during INT
//   int_vec      index of the last accepted interrupt
//   in_service   interrupt service active
module control_sequencer #(
  parameter int OP_W      = 8,
  parameter int N_INT     = 5,
  parameter int CYC_W     = 3,
  parameter int MAX_BYTES = 3,
  localparam int LEN_W    = $clog2(MAX_BYTES + 1),
  localparam int VEC_W    = $clog2(N_INT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [OP_W-1:0]               mem_data,
  input  logic                          mem_ready,
  input  logic [LEN_W-1:0]              instr_bytes,
  input  logic [CYC_W-1:0]              exec_cycles,
  input  logic [N_INT-1:0]              int_req,
  input  logic                          int_en,
  input  logic                          reti,
  output logic                          fetch,
  output logic                          decode,
  output logic                          execute,
  output logic                          exec_last,
  output logic                          pc_inc,
  output logic [OP_W-1:0]               opcode_q,
  output logic [(MAX_BYTES-1)*OP_W-1:0] operand_q,
  output logic [N_INT-1:0]              int_ack,
  output logic [VEC_W-1:0]              int_vec,
  output logic                          in_service
);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_EXECUTE = 3'd4,
    ST_INT     = 3'd5
  } state_t;

  localparam logic [LEN_W:0] MAX_B = (LEN_W + 1)'(MAX_BYTES);

  state_t                          state_q, state_d;
  logic [OP_W-1:0]                 opcode_d;
  logic [(MAX_BYTES-1)*OP_W-1:0]   operand_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [LEN_W-1:0]                byte_idx_q, byte_idx_d;
  logic [CYC_W-1:0]                cyc_cnt_q, cyc_cnt_d;
  logic [VEC_W-1:0]                int_vec_q, int_vec_d;
  logic                            in_service_q, in_service_d;
  logic [N_INT-1:0]                pend_q, pend_d;

  logic [LEN_W:0]                  ib_w;
  logic [LEN_W-1:0]                len_dec;
  logic [N_INT-1:0]                sel_req;
  logic [N_INT-1:0]                enc_ack;
  logic [VEC_W-1:0]                enc_vec;

  // Length clamp to 1..MAX_BYTES; compared one bit wider so the upper bound
  // stays meaningful for any MAX_BYTES.
  always_comb begin
    ib_w = {1'b0, instr_bytes};
    if (ib_w == '0)
      len_dec = LEN_W'(1);
    else if (ib_w > MAX_B)
      len_dec = LEN_W'(MAX_BYTES);
    else
      len_dec = instr_bytes;
  end

  // Requests are resampled in INT; if they have all gone away, the set seen
  // at the EXECUTE decision still selects the vector.
  always_comb begin
    sel_req = (|int_req) ? int_req : pend_q;
    enc_ack = '0;
    enc_vec = '0;
    for (int i = N_INT - 1; i >= 0; i--) begin
      if (sel_req[i]) begin
        enc_ack    = '0;
        enc_ack[i] = 1'b1;
        enc_vec    = VEC_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    operand_d    = operand_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    cyc_cnt_d    = cyc_cnt_q;
    int_vec_d    = int_vec_q;
    in_service_d = in_service_q;
    pend_d       = pend_q;
    fetch        = 1'b0;
    decode       = 1'b0;
    execute      = 1'b0;
    exec_last    = 1'b0;
    int_ack      = '0;

    if (reti)
      in_service_d = 1'b0;

    case (state_q)
      ST_START: state_d = ST_FETCH;

      ST_FETCH: begin
        fetch = 1'b1;
        if (mem_ready) begin
          opcode_d = mem_data;
          state_d  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        decode = 1'b1;
        len_d  = len_dec;
        // The execute counter is loaded here and held untouched through OPERAND.
        cyc_cnt_d = (exec_cycles == '0) ? CYC_W'(1) : exec_cycles;
        if (len_dec == LEN_W'(1)) begin
          state_d = ST_EXECUTE;
        end else begin
          byte_idx_d = LEN_W'(1);
          state_d    = ST_OPERAND;
        end
      end

      ST_OPERAND: begin
        fetch = 1'b1;
        if (mem_ready) begin
          for (int i = 1; i < MAX_BYTES; i++) begin
            if (byte_idx_q == LEN_W'(i))
              operand_d[(i-1)*OP_W +: OP_W] = mem_data;
          end
          if (byte_idx_q == len_q - LEN_W'(1))
            state_d = ST_EXECUTE;
          else
            byte_idx_d = byte_idx_q + LEN_W'(1);
        end
      end

      ST_EXECUTE: begin
        execute = 1'b1;
        if (cyc_cnt_q <= CYC_W'(1)) begin
          exec_last = 1'b1;
          if (int_en && (|int_req) && !in_service_q) begin
            pend_d  = int_req;
            state_d = ST_INT;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q - CYC_W'(1);
        end
      end

      ST_INT: begin
        int_ack      = enc_ack;
        int_vec_d    = enc_vec;
        in_service_d = 1'b1;  // overrides a coincident reti
        state_d      = ST_FETCH;
      end

      default: state_d = ST_START;
    endcase
  end

  assign pc_inc     = fetch & mem_ready;
  assign int_vec    = int_vec_q;
  assign in_service = in_service_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_START;
      opcode_q     <= '0;
      operand_q    <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      cyc_cnt_q    <= '0;
      int_vec_q    <= '0;
      in_service_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      cyc_cnt_q    <= cyc_cnt_d;
      int_vec_q    <= int_vec_d;
      in_service_q <= in_service_d;
      pend_q       <= pend_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clock;
  logic        reset_n;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic [1:0]  instr_bytes;
  logic [2:0]  exec_cycles;
  logic [4:0]  int_req;
  logic        int_en;
  logic        reti;
  logic        fetch, decode, execute, exec_last, pc_inc;
  logic [7:0]  opcode_q;
  logic [15:0] operand_q;
  logic [4:0]  int_ack;
  logic [2:0]  int_vec;
  logic        in_service;

  control_sequencer dut (
    .clock       (clock),
    .reset       (reset_n),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .instr_bytes (instr_bytes),
    .exec_cycles (exec_cycles),
    .int_req     (int_req),
    .int_en      (int_en),
    .reti        (reti),
    .fetch       (fetch),
    .decode      (decode),
    .execute     (execute),
    .exec_last   (exec_last),
    .pc_inc      (pc_inc),
    .opcode_q    (opcode_q),
    .operand_q   (operand_q),
    .int_ack     (int_ack),
    .int_vec     (int_vec),
    .in_service  (in_service)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [37:0] obs;
  assign obs = {fetch, decode, execute, exec_last, pc_inc, int_ack, int_vec,
                in_service, opcode_q, operand_q};

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // One instruction as the program/decoder/interrupt environment presents it.
  typedef struct {
    logic [7:0] op;
    logic [1:0] ib;
    logic [2:0] ec;
    logic [7:0] b1, b2;
    int         sf, s1, s2;     // stall cycles before opcode, byte 1, byte 2
    logic       en;
    logic [4:0] req;
    logic       drop;           // requests vanish during INT
    logic       reti_f;         // reti on the first fetch cycle
    logic       reti_i;         // reti on the INT cycle
  } instr_t;

  // One clock cycle of stimulus plus the outputs expected during it.
  typedef struct {
    logic [7:0]  md;
    logic        mr;
    logic [1:0]  ib;
    logic [2:0]  ec;
    logic [4:0]  req;
    logic        en;
    logic        reti;
    logic [37:0] exp;
    int          ph;
  } cyc_t;

  cyc_t tl[$];
  int   opnd_mark;

  logic [7:0]  m_op;
  logic [15:0] m_opnd;
  logic [2:0]  m_vec;
  logic        m_isv;

  function automatic instr_t mk(input logic [7:0] op, input logic [1:0] ib, input logic [2:0] ec);
    instr_t p;
    p.op = op; p.ib = ib; p.ec = ec; p.b1 = 8'h00; p.b2 = 8'h00;
    p.sf = 0; p.s1 = 0; p.s2 = 0; p.en = 1'b0; p.req = 5'b0;
    p.drop = 1'b0; p.reti_f = 1'b0; p.reti_i = 1'b0;
    return p;
  endfunction

  function automatic cyc_t filler(input int ph);
    cyc_t c;
    c.md = 8'($urandom); c.mr = 1'($urandom); c.ib = 2'($urandom);
    c.ec = 3'($urandom); c.req = 5'($urandom); c.en = 1'($urandom);
    c.reti = 1'b0; c.ph = ph; c.exp = '0;
    return c;
  endfunction

  function automatic int lowest(input logic [4:0] r);
    for (int i = 0; i < 5; i++) if (r[i]) return i;
    return 0;
  endfunction

  task automatic emit(input cyc_t c_in, input logic [4:0] st, input logic [4:0] ack);
    cyc_t c;
    c = c_in;
    c.exp = {st, ack, m_vec, m_isv, m_op, m_opnd};
    tl.push_back(c);
  endtask

  // Expands a program into the expected cycle-by-cycle timeline.
  task automatic gen(input instr_t prog[$]);
    cyc_t c;
    tl.delete();
    opnd_mark = -1;
    m_op = '0; m_opnd = '0; m_vec = '0; m_isv = 1'b0;
    c = filler(0);
    emit(c, 5'b00000, 5'b0);
    foreach (prog[n]) begin
      instr_t p;
      logic rp;
      int len, cyc;
      p  = prog[n];
      rp = p.reti_f;
      for (int s = 0; s < p.sf; s++) begin
        c = filler(1); c.mr = 1'b0; c.reti = rp; rp = 1'b0;
        emit(c, 5'b10000, 5'b0);
        if (c.reti) m_isv = 1'b0;
      end
      c = filler(1); c.mr = 1'b1; c.md = p.op; c.reti = rp; rp = 1'b0;
      emit(c, 5'b10001, 5'b0);
      m_op = p.op;
      if (c.reti) m_isv = 1'b0;
      c = filler(2); c.ib = p.ib; c.ec = p.ec;
      emit(c, 5'b01000, 5'b0);
      len = (p.ib == 0) ? 1 : ((p.ib > 3) ? 3 : int'(p.ib));
      cyc = (p.ec == 0) ? 1 : int'(p.ec);
      for (int b = 1; b < len; b++) begin
        int st;
        logic [7:0] v;
        st = (b == 1) ? p.s1 : p.s2;
        v  = (b == 1) ? p.b1 : p.b2;
        for (int s = 0; s < st; s++) begin
          c = filler(3); c.mr = 1'b0;
          if (b == 2 && opnd_mark < 0) opnd_mark = tl.size();
          emit(c, 5'b10000, 5'b0);
        end
        c = filler(3); c.mr = 1'b1; c.md = v;
        if (b == 2 && opnd_mark < 0) opnd_mark = tl.size();
        emit(c, 5'b10001, 5'b0);
        m_opnd[(b-1)*8 +: 8] = v;
      end
      for (int k = 1; k <= cyc; k++) begin
        c = filler(4); c.en = p.en; c.req = p.req;
        emit(c, (k == cyc) ? 5'b00110 : 5'b00100, 5'b0);
      end
      if (p.en && (p.req != 0) && !m_isv) begin
        logic [4:0] ack;
        ack = 5'b0;
        ack[lowest(p.req)] = 1'b1;
        c = filler(5); c.req = p.drop ? 5'b0 : p.req; c.reti = p.reti_i;
        emit(c, 5'b00000, ack);
        m_vec = 3'(lowest(p.req));
        m_isv = 1'b1;
      end
    end
  endtask

  task automatic drive(input cyc_t c);
    mem_data = c.md; mem_ready = c.mr; instr_bytes = c.ib; exec_cycles = c.ec;
    int_req = c.req; int_en = c.en; reti = c.reti;
  endtask

  // Plays the timeline; rst_at >= 0 asserts reset asynchronously mid-cycle there.
  task automatic run(input int tno, input int rst_at);
    reset_n = 1'b0;
    mem_ready = 1'b0; reti = 1'b0; int_en = 1'b0; int_req = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check($sformatf("t%0d reset", tno), 64'(obs), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < tl.size(); k++) begin
      drive(tl[k]);
      #1;
      check($sformatf("t%0d c%0d ph%0d", tno, k, tl[k].ph), 64'(obs), 64'(tl[k].exp));
      if (k == rst_at) begin
        #2;
        reset_n = 1'b0;
        #1;
        check($sformatf("t%0d async_reset", tno), 64'(obs), 64'(0));
        break;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    instr_t prog[$];
    instr_t p;

    reset_n = 1'b0; mem_data = '0; mem_ready = 1'b0; instr_bytes = '0;
    exec_cycles = '0; int_req = '0; int_en = 1'b0; reti = 1'b0;

    // 1: back-to-back single-byte, single-cycle instructions
    prog.delete();
    repeat (4) prog.push_back(mk(8'h04, 2'd1, 3'd1));
    gen(prog); run(1, -1);

    // 2: three-byte instruction with a stall before byte 2, two execute cycles
    prog.delete();
    p = mk(8'h90, 2'd3, 3'd2); p.b1 = 8'h12; p.b2 = 8'h34; p.s2 = 2;
    prog.push_back(p);
    prog.push_back(mk(8'h04, 2'd1, 3'd1));
    gen(prog); run(2, -1);

    // 3: interrupt entry, in-service lock, reti, re-entry
    prog.delete();
    p = mk(8'h11, 2'd1, 3'd2); p.en = 1'b1; p.req = 5'b10100; prog.push_back(p);
    p = mk(8'h22, 2'd1, 3'd1); p.en = 1'b1; p.req = 5'b00001; prog.push_back(p);
    p = mk(8'h33, 2'd2, 3'd1); p.b1 = 8'h5a; p.en = 1'b1; p.req = 5'b00010;
    p.reti_f = 1'b1; p.sf = 1; prog.push_back(p);
    prog.push_back(mk(8'h44, 2'd1, 3'd1));
    gen(prog); run(3, -1);

    // 4: interrupts masked by int_en
    prog.delete();
    for (int i = 0; i < 10; i++) begin
      p = mk(8'($urandom), 2'($urandom), 3'($urandom));
      p.b1 = 8'($urandom); p.b2 = 8'($urandom); p.req = 5'b11111;
      prog.push_back(p);
    end
    gen(prog); run(4, -1);

    // 5: asynchronous reset in the middle of OPERAND
    prog.delete();
    p = mk(8'h55, 2'd1, 3'd1); p.en = 1'b1; p.req = 5'b00010; p.drop = 1'b1;
    prog.push_back(p);
    p = mk(8'h66, 2'd3, 3'd3); p.b1 = 8'hab; p.b2 = 8'hcd; p.s2 = 3;
    prog.push_back(p);
    gen(prog); run(5, opnd_mark);

    // 6: zero length/count clamp, reti coincident with INT
    prog.delete();
    prog.push_back(mk(8'h77, 2'd0, 3'd0));
    p = mk(8'h78, 2'd0, 3'd0); p.en = 1'b1; p.req = 5'b01000; p.reti_i = 1'b1;
    prog.push_back(p);
    p = mk(8'h79, 2'd0, 3'd0); p.en = 1'b1; p.req = 5'b00001;
    prog.push_back(p);
    gen(prog); run(6, -1);

    // 7: random programs
    prog.delete();
    for (int i = 0; i < 60; i++) begin
      p = mk(8'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      p.b1 = 8'($urandom); p.b2 = 8'($urandom);
      p.sf = $urandom_range(0, 2); p.s1 = $urandom_range(0, 2); p.s2 = $urandom_range(0, 2);
      p.en = 1'($urandom_range(0, 1));
      p.req = ($urandom_range(0, 2) == 0) ? 5'b0 : 5'($urandom);
      p.drop = 1'($urandom_range(0, 1));
      p.reti_f = ($urandom_range(0, 3) == 0);
      p.reti_i = ($urandom_range(0, 7) == 0);
      prog.push_back(p);
    end
    gen(prog); run(7, -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised instruction sequencer for the 8051 core: START → FETCH → DECODE → OPERAND → EXECUTE, plus interrupt entry.
- Compared with the earlier fixed fetch/decode/execute loop, it adds:
  - a memory-ready handshake;
  - multi-byte operand fetch;
  - multi-cycle execute;
  - prioritised interrupt entry with a single-level in-service lock.
- Sits between program memory/PC logic and the datapath; the decoder supplies instruction length and cycle count.

Parameters:
- OP_W, 8, opcode width in bits.
- N_INT, 5, number of interrupt request lines. Index 0 is the highest priority.
- CYC_W, 3, width of the execute-cycle count.
- MAX_BYTES, 3, maximum instruction length in bytes (≥1).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_data  in  OP_W  program memory read data.
- mem_ready  in  1  memory handshake; the byte on mem_data is valid this cycle.
- instr_bytes  in  $clog2(MAX_BYTES+1)  decoder length for opcode_q; sampled in DECODE.
- exec_cycles  in  CYC_W  decoder execute-cycle count; sampled in DECODE.
- int_req  in  N_INT  level-sensitive interrupt requests.
- int_en  in  1  global interrupt enable.
- reti  in  1  single-cycle pulse; clears in-service.
- fetch  out  1  high in FETCH and OPERAND.
- decode  out  1  high in DECODE.
- execute  out  1  high in EXECUTE.
- exec_last  out  1  high on the final EXECUTE cycle.
- pc_inc  out  1  equals fetch & mem_ready.
- opcode_q  out  OP_W  latched opcode.
- operand_q  out  (MAX_BYTES-1)*OP_W  latched operand bytes; byte 1 in the low OP_W bits.
- int_ack  out  N_INT  one-hot pulse during INT.
- int_vec  out  $clog2(N_INT)  index of the accepted interrupt, held until the next INT.
- in_service  out  1  interrupt service active.

Behaviour:
- **Reset (reset=0, immediate, asynchronous):**
  - state=START; opcode_q, operand_q, int_vec = 0; in_service=0; byte/cycle counters = 0.
  - All strobes = 0.
  - Reset mid-operation aborts any fetch or execute with no residual effect.
- **START:** exactly one cycle, then → FETCH.
- **FETCH:**
  - Waits while mem_ready=0, for unlimited stall cycles.
  - On mem_ready=1: opcode_q ← mem_data, then → DECODE.
- **DECODE:** one cycle.
  - Latch len = instr_bytes. Values 0 and >MAX_BYTES are clamped to the range 1..MAX_BYTES.
  - Latch cyc = exec_cycles, with 0 treated as 1.
  - len=1 → EXECUTE; otherwise byte_idx=1 → OPERAND.
- **OPERAND:**
  - Each mem_ready=1 cycle stores mem_data into operand_q slot byte_idx and increments byte_idx.
  - When the stored byte is number len-1 → EXECUTE.
  - Stalls exactly as in FETCH.
- **EXECUTE:**
  - Stays for cyc cycles; a down-counter is loaded on entry.
  - exec_last=1 when the count reaches 1.
  - At the end of exec_last:
    - if int_en & |int_req & !in_service → INT;
    - else → FETCH.
  - A new instruction fetch starts the cycle after exec_last.
- **INT:** one cycle.
  - int_ack has exactly one bit set: the lowest-index asserted int_req.
  - int_vec ← that index; in_service ← 1; then → FETCH.
  - int_req is resampled in INT. If it dropped since the EXECUTE decision, INT still pulses, using the lowest index among the requests seen in EXECUTE.
- **reti:** clears in_service on the next edge. If reti=1 in the same cycle INT sets in_service, the set wins.
- **Interrupt timing:** interrupts are taken only at instruction boundaries, never during FETCH/OPERAND/DECODE.
- **Illegal state encoding:** → START on the next edge.
- **Outputs:** fetch, decode and execute are mutually exclusive; all three are 0 in START and INT.

Test Plan:
1. Release reset with mem_ready=1, len=1, cyc=1, opcode 0x04 → one START cycle, then a repeating FETCH/DECODE/EXECUTE pattern of period 3; opcode_q=0x04; pc_inc once per instruction.
2. Opcode 0x90 with len=3, operand bytes 0x12 then 0x34, cyc=2, and mem_ready low for 2 cycles before byte 2 → operand_q=0x3412; 3 pc_inc pulses; execute high 2 cycles, exec_last on the 2nd.
3. int_en=1, int_req=5'b10100 asserted mid-EXECUTE → after exec_last, INT with int_ack=5'b00100, int_vec=2, in_service=1; a second request is ignored until a reti pulse, then taken at the next boundary.
4. int_en=0 with int_req=5'b11111 → no INT entry over 10 instructions; int_ack stays 0.
5. Drive reset=0 asynchronously mid-OPERAND → outputs clear without waiting for a clock edge; restart begins at START.
6. instr_bytes=0 and exec_cycles=0 → treated as len=1, cyc=1; single-cycle execute; no OPERAND state.
